// File: rtl/lsu_align.sv
// lsu_align: byte-addressed RV32I load/store front end for a word-addressed
// data memory with a one-cycle registered read. One request in flight.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; a response transfers on the rising edge where
// resp_valid and resp_ready are both high. While resp_valid is high,
// resp_data and resp_err hold steady until that transfer.
module lsu_align #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LWAIT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  mode_q, mode_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic [1:0]  size;
  logic        funct_ok;
  logic        align_ok;
  logic        legal;
  logic [3:0]  lane_mask;
  logic        load_signed;
  logic [31:0] load_ext;

  // Byte-address bits above the memory's word index are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Request decode: legality, lane mask and signedness of the access.
  always_comb begin
    accept = req_valid & (state_q == IDLE);
    size   = req_funct3[1:0];
    if (req_we) begin
      funct_ok = ~req_funct3[2] & (size != 2'b11);
    end else begin
      funct_ok = (size != 2'b11) & ~(req_funct3[2] & (size == 2'b10));
    end
    case (size)
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    legal = funct_ok & align_ok;
    case (size)
      2'b00:   lane_mask = 4'b0001 << req_addr[1:0];
      2'b01:   lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
    load_signed = ~req_funct3[2] & (size != 2'b10);
  end

  // Memory-side drive: only during an accepting cycle, only for legal accesses.
  always_comb begin
    wmem       = 4'b0000;
    rmem       = 5'b00000;
    mem_addr   = 32'd0;
    store_data = 32'd0;
    if (accept) begin
      mem_addr   = {{(32-ADDR_WIDTH){1'b0}}, req_addr[ADDR_WIDTH+1:2]};
      store_data = req_wdata;
      if (legal) begin
        if (req_we) begin
          wmem = lane_mask;
        end else begin
          rmem = {load_signed, lane_mask};
        end
      end
    end
  end

  // Lane extraction of the returned word using the latched load mode.
  always_comb begin
    load_ext = load_data;
    case (mode_q[3:0])
      4'b0001: load_ext = {{24{mode_q[4] & load_data[7]}},  load_data[7:0]};
      4'b0010: load_ext = {{24{mode_q[4] & load_data[15]}}, load_data[15:8]};
      4'b0100: load_ext = {{24{mode_q[4] & load_data[23]}}, load_data[23:16]};
      4'b1000: load_ext = {{24{mode_q[4] & load_data[31]}}, load_data[31:24]};
      4'b0011: load_ext = {{16{mode_q[4] & load_data[15]}}, load_data[15:0]};
      4'b1100: load_ext = {{16{mode_q[4] & load_data[31]}}, load_data[31:16]};
      default: load_ext = load_data;
    endcase
  end

  // Next-state logic for the IDLE -> (LWAIT) -> RESP -> IDLE sequence.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal & ~req_we) begin
            mode_d  = rmem;
            state_d = LWAIT;
          end else begin
            resp_data_d = 32'd0;
            resp_err_d  = ~legal;
            state_d     = RESP;
          end
        end
      end
      LWAIT: begin
        resp_data_d = load_ext;
        resp_err_d  = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_data_d = 32'd0;
          resp_err_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 5'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed cases plus randomized requests, with a
// byte-arithmetic reference model and a response scoreboard.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];   // {err, data}

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  lsu_align #(.ADDR_WIDTH(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .wmem       (wmem),
    .rmem       (rmem),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .load_data  (load_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: access size in bytes, byte offset, shift and mask arithmetic.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] word,
                                output logic [3:0] wm, output logic [4:0] rm,
                                output logic [31:0] rdata, output bit err, output bit lload);
    int     nbytes;
    int     off;
    bit     legal;
    bit     sgn;
    int     lanes;
    longint v;
    longint full;
    nbytes = 1 << f3[1:0];
    off    = int'(addr[1:0]);
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (legal && (off % nbytes) != 0) legal = 0;
    lanes = ((1 << nbytes) - 1) << off;
    sgn   = (f3[2] == 1'b0) && (nbytes < 4);
    err   = !legal;
    lload = legal && !we;
    wm    = (legal && we) ? 4'(lanes) : 4'b0000;
    rm    = lload ? {sgn, 4'(lanes)} : 5'b00000;
    rdata = 32'd0;
    if (lload) begin
      full = longint'(1) << (8 * nbytes);
      v    = (longint'({32'd0, word}) >> (8 * off)) & (full - 1);
      if (sgn && v >= full / 2) v = v - full;
      rdata = v[31:0];
    end
  endfunction

  // Response monitor: compares every completed response with the scoreboard.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got data %h err %b with empty queue", resp_data, resp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_data", resp_data, e[31:0]);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
      end
    end
  end

  // Driver: entered just after a rising edge with the DUT idle; returns the same way.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word, input bit rdy_rand);
    logic [3:0]  e_wm;
    logic [4:0]  e_rm;
    logic [31:0] e_data;
    bit          e_err;
    bit          lload;
    bit          done;
    model(we, f3, addr, word, e_wm, e_rm, e_data, e_err, lload);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);  // cycle T
    chk("req_ready_T", {31'd0, req_ready}, 32'd1);
    chk("wmem_T", {28'd0, wmem}, {28'd0, e_wm});
    chk("rmem_T", {27'd0, rmem}, {27'd0, e_rm});
    if (!e_err) chk("mem_addr_T", mem_addr, {17'd0, addr[16:2]});
    if (!e_err && we) chk("store_data_T", store_data, wdata);
    exp_q.push_back({e_err, e_data});
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    load_data  = word;
    @(negedge clk);  // T+1
    chk("resp_valid_T1", {31'd0, resp_valid}, {31'd0, !lload});
    chk("req_ready_T1", {31'd0, req_ready}, 32'd0);
    if (lload) begin
      @(posedge clk); #1;
      load_data = $urandom;
      @(negedge clk);  // T+2
      chk("resp_valid_T2", {31'd0, resp_valid}, 32'd1);
    end
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (resp_valid && resp_ready) done = 1;
      else begin
        @(posedge clk); #1;
        resp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL handshake_timeout: resp_valid %b resp_ready %b", resp_valid, resp_ready);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    load_data  = 32'd0;
    resp_ready = 1'b0;
    #1;
    // Asynchronous reset state, before any clock edge
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_wmem", {28'd0, wmem}, 32'd0);
    chk("rst_rmem", {27'd0, rmem}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_req(1'b1, 3'b000, 32'h0000_0006, 32'h1234_56AB, 32'h0, 1'b0);  // SB
    do_req(1'b0, 3'b000, 32'h0000_0007, 32'h0, 32'h80FF_0000, 1'b0);  // LB
    do_req(1'b0, 3'b100, 32'h0000_0007, 32'h0, 32'h80FF_0000, 1'b0);  // LBU
    do_req(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_1234, 1'b0);  // LH
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);  // LW
    do_req(1'b1, 3'b010, 32'h0000_0005, 32'hCAFE_F00D, 32'h0, 1'b0);  // SW misaligned
    do_req(1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h1111_2222, 1'b0);  // LH misaligned
    do_req(1'b0, 3'b111, 32'h0000_0000, 32'h0, 32'h3333_4444, 1'b0);  // illegal load funct3
    do_req(1'b1, 3'b011, 32'h0000_0008, 32'h5555_6666, 32'h0, 1'b0);  // illegal store funct3
    do_req(1'b0, 3'b101, 32'hFFFF_FFFE, 32'h0, 32'h8765_4321, 1'b0);  // LHU, upper addr bits

    // Backpressure on an LW, then reset while the response is pending
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0010;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_rmem_T", {27'd0, rmem}, 32'h0000_000F);
    chk("bp_mem_addr_T", mem_addr, 32'd4);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    load_data = 32'hDEAD_BEEF;
    req_addr  = 32'h0000_0020;  // still valid, must be ignored outside IDLE
    @(posedge clk); #1;
    load_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resp_data", resp_data, 32'hDEAD_BEEF);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_idle_rmem", {27'd0, rmem}, 32'd0);
      @(posedge clk); #1;
      load_data = $urandom;
    end
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'h0000_7F00, 1'b0);  // LB after reset

    // Randomized requests with random response backpressure
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 2) == 0) a[1] = 1'b0;
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom, 1'b1);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
